ir_key_ctrl: RTL



---
 rtl/ir_key_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ir_key_ctrl.sv
// rtl/ir_key_ctrl.sv - NEC frame validation, key-held/auto-repeat tracking and 4-entry key FIFO.
// Optional macro IR_KEY_STAT_EN adds saturating accepted/rejected frame counters.
module ir_key_ctrl #(
    parameter logic [15:0] CUSTOM_CODE = 16'h00FF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd6_000_000,
    parameter logic [3:0]  RPT_DELAY   = 4'd3,
    parameter logic [3:0]  RPT_RATE    = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    input  logic        i_repeat,
    output logic [7:0]  o_key,
    output logic        o_key_vld,
    input  logic        i_key_rdy,
    output logic        o_held,
    output logic        o_release,
    output logic        o_err,
    output logic        o_ovf
`ifdef IR_KEY_STAT_EN
    ,
    output logic [15:0] o_stat_ok,
    output logic [15:0] o_stat_err
`endif
);

    typedef enum logic {S_IDLE, S_HELD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_tmo_cnt, w_tmo_nxt;
    logic [3:0]  r_rpt_cnt, w_rpt_nxt;
    logic [7:0]  r_held_key, w_key_nxt;
    logic        r_release, r_err, r_ovf;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr_ptr, r_rd_ptr;
    logic [2:0]  r_count;

    logic        w_frame_ok, w_frame_err, w_rep;
    logic [3:0]  w_rpt_inc, w_rpt_diff;
    logic        w_rpt_push, w_push, w_release;
    logic [7:0]  w_push_key;
    logic        w_pop, w_full, w_wr, w_ovf;

    always_comb begin
        w_frame_ok  = i_frame_vld && (i_frame[31:16] == CUSTOM_CODE) && (i_frame[15:8] == ~i_frame[7:0]);
        w_frame_err = i_frame_vld && !w_frame_ok;
        w_rep       = i_repeat && !i_frame_vld;
        w_rpt_inc   = (r_rpt_cnt == 4'hF) ? r_rpt_cnt : r_rpt_cnt + 4'd1;
        w_rpt_diff  = w_rpt_inc - RPT_DELAY;
        // Auto-repeat only fires while the repeat counter is still advancing.
        w_rpt_push  = (r_rpt_cnt != 4'hF) && (w_rpt_inc >= RPT_DELAY) && ((w_rpt_diff % RPT_RATE) == 4'd0);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_nxt   = r_tmo_cnt;
        w_rpt_nxt   = r_rpt_cnt;
        w_key_nxt   = r_held_key;
        w_push      = 1'b0;
        w_push_key  = r_held_key;
        w_release   = 1'b0;
        if (w_frame_ok) begin
            w_state_nxt = S_HELD;
            w_tmo_nxt   = 32'd0;
            w_rpt_nxt   = 4'd0;
            w_key_nxt   = i_frame[15:8];
            w_push      = 1'b1;
            w_push_key  = i_frame[15:8];
        end else if (r_state == S_HELD) begin
            if (w_rep) begin
                w_tmo_nxt = 32'd0;
                w_rpt_nxt = w_rpt_inc;
                w_push    = w_rpt_push;
            end else if (r_tmo_cnt == TIMEOUT_CYC - 32'd1) begin
                w_state_nxt = S_IDLE;
                w_release   = 1'b1;
            end else begin
                w_tmo_nxt = r_tmo_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tmo_cnt  <= 32'd0;
            r_rpt_cnt  <= 4'd0;
            r_held_key <= 8'h00;
            r_release  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_rpt_cnt  <= w_rpt_nxt;
            r_held_key <= w_key_nxt;
            r_release  <= w_release;
            r_err      <= w_frame_err;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        w_pop  = (r_count != 3'd0) && i_key_rdy;
        w_full = (r_count == 3'd4);
        w_wr   = w_push && (!w_full || w_pop);
        w_ovf  = w_push && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_wr} - {2'b00, w_pop};
            r_ovf   <= w_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_push_key;
        end
    end

    assign o_key     = (r_count != 3'd0) ? r_mem[r_rd_ptr] : 8'h00;
    assign o_key_vld = (r_count != 3'd0);
    assign o_held    = (r_state == S_HELD);
    assign o_release = r_release;
    assign o_err     = r_err;
    assign o_ovf     = r_ovf;

`ifdef IR_KEY_STAT_EN
    logic [15:0] r_stat_ok, r_stat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ok  <= 16'h0000;
            r_stat_err <= 16'h0000;
        end else begin
            if (w_frame_ok && r_stat_ok != 16'hFFFF) begin
                r_stat_ok <= r_stat_ok + 16'd1;
            end
            if (w_frame_err && r_stat_err != 16'hFFFF) begin
                r_stat_err <= r_stat_err + 16'd1;
            end
        end
    end

    assign o_stat_ok  = r_stat_ok;
    assign o_stat_err = r_stat_err;
`endif

endmodule
